bcd_operand_entry: RTL
======================

Name: bcd_operand_entry

Overview:
- Parametrised successor to the calculator input register. Holds NUM_OPS operand registers, each DIGITS BCD nibbles wide.
- Operands are built digit by digit from keypad strobes, using shift-left-and-insert. Backspace, per-operand clear and parallel load (ALU result writeback for chained operations) are also supported.
- Sits between keypad decoder and ALU/display; all operands are exposed in parallel.

Parameters:
- DIGITS, 4, BCD digit positions per operand (>=1); operand width W = 4*DIGITS.
- NUM_OPS, 2, number of operand registers (>=2).
- SELW, $clog2(NUM_OPS), width of operand select.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset, whole block.
- sel  in  SELW  target operand for all commands this cycle.
- digit_valid  in  1  push digit into sel operand.
- digit  in  4  BCD digit, valid 0..9.
- backspace  in  1  drop least-significant digit of sel operand.
- clr_op  in  1  synchronous clear of sel operand only.
- load  in  1  parallel load D into sel operand.
- D  in  W  parallel BCD load data.
- Q  out  NUM_OPS*W  all operands; operand k at Q[k*W +: W].
- cnt  out  $clog2(DIGITS+1)  significant-digit count of sel operand (combinational from sel).
- full  out  1  cnt==DIGITS for sel operand.
- ovf  out  NUM_OPS  sticky per-operand overflow flags.
- err  out  1  registered one-cycle pulse on rejected command.

Behaviour:
- Reset: clear=1 asynchronously forces all operand values=0, all counts=0, ovf=0, err=0, regardless of clk. Commands are ignored while clear=1. Deasserting clear mid-entry resumes from all-zero.
- State per operand: value[W-1:0] (packed BCD) and count 0..DIGITS. All updates happen on the rising clk edge with 1-cycle latency to Q. Only the sel operand changes; all others hold.
- Command priority, one action per cycle: load > clr_op > backspace > digit_valid. Lower-priority commands in the same cycle are dropped silently (no err).
- load:
  - If every nibble of D is <=9: value<=D, count<=index of highest nonzero nibble+1 (0 if D==0), ovf[sel] unchanged.
  - Otherwise: no change, err pulses.
- clr_op: value<=0, count<=0, ovf[sel]<=0.
- backspace:
  - If count>0: value<=value>>4 (zero fill), count<=count-1.
  - If count==0: no-op, no err.
- digit_valid:
  - digit>9: no change, err pulses.
  - count==0 and digit==0: leading zero suppressed; value stays 0, count stays 0, no err.
  - count==DIGITS: no change, ovf[sel]<=1 (sticky), err pulses.
  - Otherwise: value<={value[W-5:0],digit}, count<=count+1.
- err: registered, high exactly one cycle after the offending edge; cleared the next cycle unless a new rejection occurs.
- ovf[k] clears only on clear or clr_op with sel==k. load does not clear it.
- An out-of-range sel (>=NUM_OPS when NUM_OPS is not a power of 2) makes every command a no-op with an err pulse.

Test Plan:
- Reset check: clear=1 for 100 ns with random stimulus -> Q=0, cnt=0, ovf=0, err=0. Assert clear asynchronously mid-clock-period -> Q=0 before the next edge.
- Entry/overflow: sel=0; digits 0,1,2,3,4 (DIGITS=4) -> leading 0 suppressed, Q[15:0]=16'h1234, full=1. Push 5 -> Q unchanged, ovf[0]=1, err pulse; operand 1 stays 0.
- Backspace: sel=1; enter 9,8,7 -> 16'h0987, cnt=3. Backspace x4 -> 16'h0098, 16'h0009, 16'h0000, then no-op with cnt=0, no err.
- Priority: same cycle load=1 (D=16'h0502), clr_op=1, digit_valid=1 -> value=16'h0502, cnt=3. Then clr_op+backspace -> value=0, ovf cleared.
- Invalid input: digit=4'hA -> err pulse, no change. load D=16'h12F4 -> err pulse, no change.
- Operand isolation: alternate sel 0/1 entering 1,2 and 3,4 -> Q={16'h0034,16'h0012}; ovf on one operand does not affect the other.

Source files
------------

// File: rtl/bcd_operand_entry_if.sv
// ---------------------------------------------------------------------------
// bcd_operand_entry_if
//
// Command/data bundle between the keypad decoder (master) and the BCD
// operand entry block (slave).
//
// Handshake: every command (digit_valid, backspace, clr_op, load) is a
// single-cycle strobe sampled on the rising clock edge together with sel,
// digit and D. There is no ready: the block takes one command per cycle.
// A command it cannot carry out is reported through err one cycle later.
//
// Signals
//   sel          target operand for this cycle's command
//   digit_valid  push digit into the selected operand
//   digit        BCD digit, valid 0..9
//   backspace    drop the least-significant digit of the selected operand
//   clr_op       clear the selected operand and its overflow flag
//   load         parallel load of D into the selected operand
//   D            packed BCD load data, DIGITS nibbles
//   Q            all operands, operand k at Q[k*W +: W]
//   cnt          significant-digit count of the selected operand
//   full         cnt == DIGITS for the selected operand
//   ovf          sticky per-operand overflow flags
//   err          one-cycle pulse after a rejected command
// ---------------------------------------------------------------------------
interface bcd_operand_entry_if #(
  parameter int DIGITS  = 4,
  parameter int NUM_OPS = 2,
  parameter int SELW    = $clog2(NUM_OPS)
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic [SELW-1:0]      sel;
  logic                 digit_valid;
  logic [3:0]           digit;
  logic                 backspace;
  logic                 clr_op;
  logic                 load;
  logic [W-1:0]         D;
  logic [NUM_OPS*W-1:0] Q;
  logic [CW-1:0]        cnt;
  logic                 full;
  logic [NUM_OPS-1:0]   ovf;
  logic                 err;

  modport master (
    output sel, digit_valid, digit, backspace, clr_op, load, D,
    input  Q, cnt, full, ovf, err
  );

  modport slave (
    input  sel, digit_valid, digit, backspace, clr_op, load, D,
    output Q, cnt, full, ovf, err
  );
endinterface

// File: rtl/bcd_operand_entry.sv
// ---------------------------------------------------------------------------
// bcd_operand_entry
//
// NUM_OPS operand registers of DIGITS packed BCD nibbles each. Operands are
// built from keypad digits by shift-left-and-insert; backspace, per-operand
// clear and a parallel load (ALU result writeback) are also provided. All
// operands are presented in parallel on Q for the ALU and display.
//
// Ports
//   clk    system clock, rising edge
//   clear  asynchronous active-high reset of the whole block
//   bus    command/data bundle (slave side), see bcd_operand_entry_if
//
// Per cycle exactly one command acts on the selected operand, chosen by
// priority load > clr_op > backspace > digit_valid. Lower-priority strobes
// in the same cycle are dropped without an error.
//
// Each operand keeps a significant-digit count next to its value. The count
// is what makes leading-zero suppression, the full flag and overflow
// detection cheap: the value alone cannot tell "0" from "no digits yet".
// ---------------------------------------------------------------------------
module bcd_operand_entry #(
  parameter int DIGITS  = 4,
  parameter int NUM_OPS = 2,
  parameter int SELW    = $clog2(NUM_OPS)
) (
  input logic                clk,
  input logic                clear,
  bcd_operand_entry_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
  // One extra bit so the comparison also works when NUM_OPS == 2**SELW.
  localparam logic [SELW:0] OPS_LIM  = (SELW + 1)'(NUM_OPS);

  // -------------------------------------------------------------------------
  // Operand state
  // -------------------------------------------------------------------------
  logic [W-1:0]       value [NUM_OPS];
  logic [CW-1:0]      count [NUM_OPS];
  logic [NUM_OPS-1:0] ovf_r;
  logic               err_r;

  // -------------------------------------------------------------------------
  // Selected operand view
  // -------------------------------------------------------------------------
  logic          sel_ok;
  logic [W-1:0]  cur_val;
  logic [CW-1:0] cur_cnt;

  // An out-of-range select matches no operand, so cur_cnt reads as zero.
  always_comb begin
    sel_ok  = ({1'b0, bus.sel} < OPS_LIM);
    cur_val = '0;
    cur_cnt = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (bus.sel == SELW'(k)) begin
        cur_val = value[k];
        cur_cnt = count[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Load data inspection: every nibble must be a decimal digit, and the
  // significant-digit count is the position of the highest nonzero nibble.
  // -------------------------------------------------------------------------
  logic          d_is_bcd;
  logic [CW-1:0] d_cnt;

  always_comb begin
    d_is_bcd = 1'b1;
    d_cnt    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.D[4*i +: 4] > 4'd9) begin
        d_is_bcd = 1'b0;
      end
      if (bus.D[4*i +: 4] != 4'd0) begin
        d_cnt = CW'(i + 1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Command decode for the selected operand
  // -------------------------------------------------------------------------
  logic          any_cmd;
  logic          wr_en;
  logic          set_ovf;
  logic          clr_ovf;
  logic          rej;
  logic [W-1:0]  nxt_val;
  logic [CW-1:0] nxt_cnt;

  always_comb begin
    any_cmd = bus.load | bus.clr_op | bus.backspace | bus.digit_valid;
    wr_en   = 1'b0;
    set_ovf = 1'b0;
    clr_ovf = 1'b0;
    rej     = 1'b0;
    nxt_val = cur_val;
    nxt_cnt = cur_cnt;

    if (!sel_ok) begin
      rej = any_cmd;
    end else if (bus.load) begin
      if (d_is_bcd) begin
        wr_en   = 1'b1;
        nxt_val = bus.D;
        nxt_cnt = d_cnt;
      end else begin
        rej = 1'b1;
      end
    end else if (bus.clr_op) begin
      wr_en   = 1'b1;
      nxt_val = '0;
      nxt_cnt = '0;
      clr_ovf = 1'b1;
    end else if (bus.backspace) begin
      // Backspace on an empty operand is a harmless no-op.
      if (cur_cnt != '0) begin
        wr_en   = 1'b1;
        nxt_val = cur_val >> 4;
        nxt_cnt = cur_cnt - 1'b1;
      end
    end else if (bus.digit_valid) begin
      if (bus.digit > 4'd9) begin
        rej = 1'b1;
      end else if ((cur_cnt == '0) && (bus.digit == 4'd0)) begin
        // Leading zero: nothing to record, not an error.
        wr_en = 1'b0;
      end else if (cur_cnt == CNT_FULL) begin
        set_ovf = 1'b1;
        rej     = 1'b1;
      end else begin
        wr_en   = 1'b1;
        nxt_val = (cur_val << 4) | W'(bus.digit);
        nxt_cnt = cur_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State update: only the selected operand can change.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int k = 0; k < NUM_OPS; k++) begin
        value[k] <= '0;
        count[k] <= '0;
      end
      ovf_r <= '0;
      err_r <= 1'b0;
    end else begin
      err_r <= rej;
      for (int k = 0; k < NUM_OPS; k++) begin
        if (sel_ok && (bus.sel == SELW'(k))) begin
          if (wr_en) begin
            value[k] <= nxt_val;
            count[k] <= nxt_cnt;
          end
          if (set_ovf) begin
            ovf_r[k] <= 1'b1;
          end else if (clr_ovf) begin
            ovf_r[k] <= 1'b0;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_OPS; g++) begin : g_q
    assign bus.Q[g*W +: W] = value[g];
  end

  assign bus.cnt  = cur_cnt;
  assign bus.full = (cur_cnt == CNT_FULL);
  assign bus.ovf  = ovf_r;
  assign bus.err  = err_r;

endmodule
